// File: rtl/udc_pkg.sv
// Shared types and glyph constants for the up/down counter run-control sequencer.
package udc_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned SEG_W   = 7;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_RUN_UP = 3'd1,
        ST_RUN_DN = 3'd2,
        ST_PAUSE  = 3'd3,
        ST_LIMIT  = 3'd4
    } state_t;

    // One-cycle accepted presses from the four panel buttons
    typedef struct packed {
        logic clr;
        logic pause;
        logic dn;
        logic up;
    } press_t;

    localparam logic [SEG_W-1:0] SEG_UP  = 7'b0111110;
    localparam logic [SEG_W-1:0] SEG_DN  = 7'b0111101;
    localparam logic [SEG_W-1:0] SEG_OFF = 7'b1111111;

    // Direction glyph: blank only in IDLE, otherwise follows the last direction
    function automatic logic [SEG_W-1:0] dir_glyph(input state_t st, input logic last_up);
        logic [SEG_W-1:0] seg;
        if (st == ST_IDLE)
            seg = SEG_OFF;
        else if (last_up)
            seg = SEG_UP;
        else
            seg = SEG_DN;
        return seg;
    endfunction

endpackage

// File: rtl/udc_btn_debounce.sv
// Two-flop synchroniser, stability counter and rising-edge press pulse for one button.
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int unsigned    CNT_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // Any return to the accepted level restarts the stability count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync2;
                press <= sync2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/udc_sequencer.sv
// Run-control FSM for the up/down counter: debounced buttons, prescaled step tick,
// registered enable/direction/clear pulses and a direction glyph.
module udc_sequencer
    import udc_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned CLK_DIV   = 50_000_000,
    parameter int unsigned DB_CYCLES = 1_000_000,
    parameter int unsigned MAX_VAL   = 15,
    parameter int unsigned MIN_VAL   = 0,
    parameter int unsigned WRAP      = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_up,
    input  logic             btn_dn,
    input  logic             btn_pause,
    input  logic             btn_clr,
    input  logic [WIDTH-1:0] cnt_val,
    output logic             cnt_en,
    output logic             cnt_up,
    output logic             cnt_clr,
    output logic [6:0]       dir_seg,
    output logic             busy
);

    localparam int unsigned      PRE_W    = $clog2(CLK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
    localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] MIN_V    = WIDTH'(MIN_VAL);
    localparam logic             WRAP_EN  = (WRAP != 0);

    press_t           press;
    state_t           state;
    state_t           state_n;
    logic             last_up;
    logic             last_up_n;
    logic             cnt_en_n;
    logic             cnt_up_n;
    logic             cnt_clr_n;
    logic [PRE_W-1:0] presc;
    logic             run_c;
    logic             tick_c;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up    (.clk(clk), .reset(reset), .btn(btn_up),    .press(press.up));
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dn    (.clk(clk), .reset(reset), .btn(btn_dn),    .press(press.dn));
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_pause (.clk(clk), .reset(reset), .btn(btn_pause), .press(press.pause));
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr   (.clk(clk), .reset(reset), .btn(btn_clr),   .press(press.clr));

    assign run_c  = (state == ST_RUN_UP) || (state == ST_RUN_DN);
    assign tick_c = run_c && (presc == PRE_LAST);

    // Next state and next outputs; presses are checked before the tick so a press wins
    always_comb begin
        state_n   = state;
        last_up_n = last_up;
        cnt_en_n  = 1'b0;
        cnt_up_n  = cnt_up;
        cnt_clr_n = 1'b0;
        if (press.clr && state != ST_IDLE) begin
            cnt_clr_n = 1'b1;
            state_n   = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (press.clr) begin
                        cnt_clr_n = 1'b1;
                    end else if (press.dn) begin
                        state_n   = ST_RUN_DN;
                        last_up_n = 1'b0;
                    end else if (press.up) begin
                        state_n   = ST_RUN_UP;
                        last_up_n = 1'b1;
                    end
                end
                ST_RUN_UP: begin
                    if (press.pause) begin
                        state_n = ST_PAUSE;
                    end else if (press.dn) begin
                        state_n   = ST_RUN_DN;
                        last_up_n = 1'b0;
                    end else if (tick_c) begin
                        if (cnt_val != MAX_V || WRAP_EN) begin
                            cnt_en_n = 1'b1;
                            cnt_up_n = 1'b1;
                        end else begin
                            state_n = ST_LIMIT;
                        end
                    end
                end
                ST_RUN_DN: begin
                    if (press.pause) begin
                        state_n = ST_PAUSE;
                    end else if (press.up) begin
                        state_n   = ST_RUN_UP;
                        last_up_n = 1'b1;
                    end else if (tick_c) begin
                        if (cnt_val != MIN_V || WRAP_EN) begin
                            cnt_en_n = 1'b1;
                            cnt_up_n = 1'b0;
                        end else begin
                            state_n = ST_LIMIT;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (press.pause || press.dn || press.up)
                        state_n = last_up ? ST_RUN_UP : ST_RUN_DN;
                end
                ST_LIMIT: begin
                    if (last_up ? press.dn : press.up) begin
                        state_n   = last_up ? ST_RUN_DN : ST_RUN_UP;
                        last_up_n = ~last_up;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // State, prescaler and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            last_up <= 1'b0;
            presc   <= '0;
            cnt_en  <= 1'b0;
            cnt_up  <= 1'b0;
            cnt_clr <= 1'b0;
            dir_seg <= SEG_OFF;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            last_up <= last_up_n;
            if (state_n != state || !run_c || tick_c)
                presc <= '0;
            else
                presc <= presc + PRE_W'(1);
            cnt_en  <= cnt_en_n;
            cnt_up  <= cnt_up_n;
            cnt_clr <= cnt_clr_n;
            dir_seg <= dir_glyph(state_n, last_up_n);
            busy    <= (state_n == ST_RUN_UP) || (state_n == ST_RUN_DN);
        end
    end

endmodule

// File: tb/tb_udc_sequencer.sv
// Directed bench for udc_sequencer: pulse scoreboard plus level checks at fixed cycles.
module tb_udc_sequencer;

    localparam logic [6:0] G_UP  = 7'b0111110;
    localparam logic [6:0] G_DN  = 7'b0111101;
    localparam logic [6:0] G_OFF = 7'b1111111;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_up = 1'b0, btn_dn = 1'b0, btn_pause = 1'b0, btn_clr = 1'b0;
    logic [3:0] cnt_val = 4'd3;
    logic       cnt_en, cnt_up, cnt_clr, busy;
    logic [6:0] dir_seg;

    logic       rst_w = 1'b1;
    logic       w_up = 1'b0;
    logic       w_zero = 1'b0;
    logic [3:0] w_val = 4'd15;
    logic       w_en, w_cup, w_clr, w_busy;
    logic [6:0] w_seg;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        bit clr;
        bit up;
        int at;
    } ev_t;
    ev_t q[$];

    udc_sequencer #(.WIDTH(4), .CLK_DIV(4), .DB_CYCLES(3), .MAX_VAL(15), .MIN_VAL(0), .WRAP(0)) u_dut (
        .clk(clk), .reset(reset), .btn_up(btn_up), .btn_dn(btn_dn), .btn_pause(btn_pause),
        .btn_clr(btn_clr), .cnt_val(cnt_val), .cnt_en(cnt_en), .cnt_up(cnt_up),
        .cnt_clr(cnt_clr), .dir_seg(dir_seg), .busy(busy)
    );

    udc_sequencer #(.WIDTH(4), .CLK_DIV(4), .DB_CYCLES(3), .MAX_VAL(15), .MIN_VAL(0), .WRAP(1)) u_wrap (
        .clk(clk), .reset(rst_w), .btn_up(w_up), .btn_dn(w_zero), .btn_pause(w_zero),
        .btn_clr(w_zero), .cnt_val(w_val), .cnt_en(w_en), .cnt_up(w_cup),
        .cnt_clr(w_clr), .dir_seg(w_seg), .busy(w_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push(input bit clr, input bit up, input int at);
        ev_t e;
        e.clr = clr;
        e.up  = up;
        e.at  = at;
        q.push_back(e);
    endtask

    // Advance to 1 time unit after clock edge number n
    task automatic at_cyc(input int n);
        do begin
            @(posedge clk);
            #1;
        end while (cyc < n);
    endtask

    // Scoreboard monitor: every cnt_en/cnt_clr pulse must match the queue head
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].at < cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_pulse: expected %s at cycle %0d, still absent at cycle %0d",
                     q[0].clr ? "clr" : "en", q[0].at, cyc);
            void'(q.pop_front());
        end
        if (cnt_en || cnt_clr) begin
            checks++;
            if (q.size() == 0 || q[0].at != cyc) begin
                errors++;
                $display("FAIL unexpected_pulse at cycle %0d: en=%0b clr=%0b, expected none",
                         cyc, cnt_en, cnt_clr);
            end else begin
                ev_t e;
                e = q.pop_front();
                if (cnt_clr != e.clr || cnt_en == e.clr || (!e.clr && cnt_up != e.up)) begin
                    errors++;
                    $display("FAIL pulse_kind at cycle %0d: got en=%0b clr=%0b up=%0b, expected en=%0b clr=%0b up=%0b",
                             cyc, cnt_en, cnt_clr, cnt_up, !e.clr, e.clr, e.up);
                end
            end
        end
    end

    initial begin
        // Reset values
        at_cyc(3);
        check("rst_cnt_en", int'(cnt_en), 0);
        check("rst_cnt_up", int'(cnt_up), 0);
        check("rst_cnt_clr", int'(cnt_clr), 0);
        check("rst_dir_seg", int'(dir_seg), int'(G_OFF));
        check("rst_busy", int'(busy), 0);
        reset = 1'b0;

        // Count up: press accepted at 10, RUN_UP at 11, steps every 4 cycles from 15
        push(0, 1, 15); push(0, 1, 19); push(0, 1, 23);
        at_cyc(5);  btn_up = 1'b1;
        at_cyc(12);
        check("run_up_busy", int'(busy), 1);
        check("run_up_seg", int'(dir_seg), int'(G_UP));
        at_cyc(13); btn_up = 1'b0;

        // Hit MAX: tick at 27 moves to LIMIT with no pulse
        at_cyc(24); cnt_val = 4'd15;
        at_cyc(28);
        check("limit_busy", int'(busy), 0);
        check("limit_seg", int'(dir_seg), int'(G_UP));
        check("limit_cnt_up_held", int'(cnt_up), 1);
        at_cyc(30); btn_up = 1'b1;
        at_cyc(37); btn_up = 1'b0;
        check("limit_up_ignored", int'(busy), 0);

        // Reverse out of LIMIT: RUN_DN at 51, down steps at 55 and 59
        push(0, 0, 55); push(0, 0, 59);
        at_cyc(45); btn_dn = 1'b1;
        at_cyc(52);
        check("run_dn_busy", int'(busy), 1);
        check("run_dn_seg", int'(dir_seg), int'(G_DN));
        at_cyc(52); btn_dn = 1'b0;

        // Pause at 62, hold 20+ cycles, resume RUN_DN at 90, first step at 94
        at_cyc(56); btn_pause = 1'b1;
        at_cyc(62); btn_pause = 1'b0;
        at_cyc(64);
        check("pause_busy", int'(busy), 0);
        check("pause_seg", int'(dir_seg), int'(G_DN));
        at_cyc(82);
        check("pause_still_idle", int'(busy), 0);
        push(0, 0, 94); push(0, 0, 98); push(1, 0, 101);
        at_cyc(84); btn_pause = 1'b1;
        at_cyc(90); btn_pause = 1'b0;
        at_cyc(91);
        check("resume_busy", int'(busy), 1);
        check("resume_seg", int'(dir_seg), int'(G_DN));

        // Clear from RUN_DN: cnt_clr at 101, back to IDLE
        at_cyc(95); btn_clr = 1'b1;
        at_cyc(101); btn_clr = 1'b0;
        at_cyc(102);
        check("clr_idle_busy", int'(busy), 0);
        check("clr_idle_seg", int'(dir_seg), int'(G_OFF));

        // Bounced up press: single acceptance at 112, RUN_UP at 113
        at_cyc(103); cnt_val = 4'd5;
        push(0, 1, 117); push(0, 1, 121); push(0, 1, 125);
        at_cyc(105); btn_up = 1'b1;
        at_cyc(106); btn_up = 1'b0;
        at_cyc(107); btn_up = 1'b1;
        at_cyc(112);
        check("bounce_not_yet_running", int'(busy), 0);
        at_cyc(113);
        check("bounce_running", int'(busy), 1);
        at_cyc(115); btn_up = 1'b0;

        // clr and up together during RUN_UP: one cnt_clr at 128, no further steps
        push(1, 1, 128);
        at_cyc(122); btn_clr = 1'b1; btn_up = 1'b1;
        at_cyc(128); btn_clr = 1'b0; btn_up = 1'b0;
        at_cyc(130);
        check("clr_up_busy", int'(busy), 0);
        check("clr_up_seg", int'(dir_seg), int'(G_OFF));
        at_cyc(140);
        check("scoreboard_drained", q.size(), 0);

        // WRAP=1 instance: step at MAX at 153, then async reset kills the pulse
        at_cyc(141); rst_w = 1'b0;
        at_cyc(143); w_up = 1'b1;
        at_cyc(150); w_up = 1'b0;
        at_cyc(153);
        check("wrap_cnt_en", int'(w_en), 1);
        check("wrap_cnt_up", int'(w_cup), 1);
        rst_w = 1'b1;
        #1;
        check("async_rst_cnt_en", int'(w_en), 0);
        check("async_rst_busy", int'(w_busy), 0);
        check("async_rst_seg", int'(w_seg), int'(G_OFF));
        at_cyc(156);
        check("async_rst_no_pulse", int'(w_en), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
